// File: rtl/register_bank_param.sv
// Parameterised register bank with byte writes, auto-step and a shadow bank.
// Reads are registered and show the bank contents after the same edge's updates.
module register_bank_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int ADDR_W  = $clog2(NUM_REGS),
  localparam int NBYTES  = DATA_W / 8,
  localparam int BSEL_W  = (NBYTES > 2) ? $clog2(NBYTES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_write,
  input  logic [ADDR_W-1:0] reg_write,
  input  logic [DATA_W-1:0] write_data,
  input  logic              size,
  input  logic [BSEL_W-1:0] byte_sel,
  input  logic              en_step,
  input  logic [ADDR_W-1:0] step_reg,
  input  logic              step_dec,
  input  logic              step_word,
  input  logic              save,
  input  logic              restore,
  input  logic [ADDR_W-1:0] reg_read1,
  input  logic [ADDR_W-1:0] reg_read2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              step_wrap,
  output logic              shadow_valid
);

  logic [DATA_W-1:0] main_q   [NUM_REGS];
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] nxt      [NUM_REGS];
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] amt;
  logic [DATA_W:0]   sum;
  logic              step_hit;
  logic              wrap_nxt;

  // The extra top bit of sum is the carry/borrow out, i.e. the wrap flag.
  always_comb begin
    nxt      = main_q;
    wrap_nxt = 1'b0;
    cur      = main_q[step_reg];
    amt      = step_word ? DATA_W'(2) : DATA_W'(1);
    sum      = step_dec ? {1'b0, cur} - {1'b0, amt}
                        : {1'b0, cur} + {1'b0, amt};
    step_hit = en_step && !(en_write && (reg_write == step_reg));
    if (restore) begin
      nxt = shadow_q;
    end else begin
      if (step_hit) begin
        nxt[step_reg] = sum[DATA_W-1:0];
        wrap_nxt      = sum[DATA_W];
      end
      if (en_write) begin
        if (size) begin
          nxt[reg_write] = write_data;
        end else begin
          for (int b = 0; b < NBYTES; b++) begin
            if (byte_sel == BSEL_W'(b))
              nxt[reg_write][8*b +: 8] = write_data[7:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        main_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      read_data1   <= '0;
      read_data2   <= '0;
      step_wrap    <= 1'b0;
      shadow_valid <= 1'b0;
    end else begin
      main_q     <= nxt;
      read_data1 <= nxt[reg_read1];
      read_data2 <= nxt[reg_read2];
      step_wrap  <= wrap_nxt;
      if (save)
        shadow_q <= main_q;
      if (save)
        shadow_valid <= 1'b1;
      else if (restore)
        shadow_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_register_bank_param.sv
// Bench for register_bank_param: directed vector table, reset sequence,
// and randomized traffic checked against an integer reference model.
module tb_register_bank_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_write;
  logic [2:0]  reg_write;
  logic [15:0] write_data;
  logic        size;
  logic [0:0]  byte_sel;
  logic        en_step;
  logic [2:0]  step_reg;
  logic        step_dec;
  logic        step_word;
  logic        save;
  logic        restore;
  logic [2:0]  reg_read1;
  logic [2:0]  reg_read2;
  logic [15:0] read_data1;
  logic [15:0] read_data2;
  logic        step_wrap;
  logic        shadow_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic        sz;
    logic        bs;
    logic        st;
    logic [2:0]  sr;
    logic        dec;
    logic        by2;
    logic        sv;
    logic        rs;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        ew;
    logic        esv;
  } vec_t;

  register_bank_param dut (
    .clk(clk), .reset(reset),
    .en_write(en_write), .reg_write(reg_write),
    .write_data(write_data), .size(size), .byte_sel(byte_sel),
    .en_step(en_step), .step_reg(step_reg),
    .step_dec(step_dec), .step_word(step_word),
    .save(save), .restore(restore),
    .reg_read1(reg_read1), .reg_read2(reg_read2),
    .read_data1(read_data1), .read_data2(read_data2),
    .step_wrap(step_wrap), .shadow_valid(shadow_valid)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, 16-bit registers.
  int unsigned m [8];
  int unsigned s [8];
  bit          msv;

  function automatic vec_t mk(
    input logic we, input logic [2:0] wr, input logic [15:0] wd,
    input logic sz, input logic bs,
    input logic st, input logic [2:0] sr, input logic dec, input logic by2,
    input logic sv, input logic rs,
    input logic [2:0] r1, input logic [2:0] r2,
    input logic [15:0] e1, input logic [15:0] e2,
    input logic ew, input logic esv);
    vec_t v;
    v.we = we; v.wr = wr; v.wd = wd; v.sz = sz; v.bs = bs;
    v.st = st; v.sr = sr; v.dec = dec; v.by2 = by2;
    v.sv = sv; v.rs = rs; v.r1 = r1; v.r2 = r2;
    v.e1 = e1; v.e2 = e2; v.ew = ew; v.esv = esv;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m[i] = 0;
      s[i] = 0;
    end
    msv = 0;
  endtask

  task automatic model_edge(input vec_t vi, output vec_t vo);
    int unsigned nm [8];
    int          nv;
    int          d;
    int          sh;
    bit          w;
    vo = vi;
    w  = 0;
    nm = m;
    if (vi.rs) begin
      nm = s;
    end else begin
      if (vi.st && !(vi.we && vi.wr == vi.sr)) begin
        d  = vi.by2 ? 2 : 1;
        nv = int'(m[vi.sr]) + (vi.dec ? -d : d);
        w  = (nv < 0) || (nv > 65535);
        nm[vi.sr] = int'(unsigned'((nv + 65536) % 65536));
      end
      if (vi.we) begin
        if (vi.sz) begin
          nm[vi.wr] = vi.wd;
        end else begin
          sh = vi.bs ? 8 : 0;
          nm[vi.wr] = (nm[vi.wr] & ~(32'hFF << sh))
                    | ((vi.wd & 32'hFF) << sh);
        end
      end
    end
    if (vi.sv) s = m;
    if (vi.sv) msv = 1;
    else if (vi.rs) msv = 0;
    m = nm;
    vo.e1  = 16'(m[vi.r1]);
    vo.e2  = 16'(m[vi.r2]);
    vo.ew  = w;
    vo.esv = msv;
  endtask

  task automatic drive(input vec_t v);
    en_write = v.we; reg_write = v.wr; write_data = v.wd;
    size = v.sz; byte_sel = v.bs;
    en_step = v.st; step_reg = v.sr;
    step_dec = v.dec; step_word = v.by2;
    save = v.sv; restore = v.rs;
    reg_read1 = v.r1; reg_read2 = v.r2;
  endtask

  task automatic idle();
    drive(mk(0,0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0));
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input vec_t v);
    chk({tag, " rd1"}, read_data1, v.e1);
    chk({tag, " rd2"}, read_data2, v.e2);
    chk({tag, " wrap"}, 16'(step_wrap), 16'(v.ew));
    chk({tag, " shadow_valid"}, 16'(shadow_valid), 16'(v.esv));
  endtask

  // Apply one vector across a clock edge; expectations from the model.
  task automatic run_model(input string tag, input vec_t v);
    vec_t e;
    model_edge(v, e);
    drive(v);
    @(posedge clk); #1;
    check_out(tag, e);
  endtask

  vec_t tbl [$];
  vec_t dummy;

  initial begin
    reset = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", mk(0,0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0));
    #3 reset = 1'b1;

    tbl.push_back(mk(1,0,16'hABCD,1,0, 0,0,0,0, 0,0, 0,0, 16'hABCD,16'hABCD,0,0));
    tbl.push_back(mk(1,1,16'h00EF,0,0, 0,0,0,0, 0,0, 1,0, 16'h00EF,16'hABCD,0,0));
    tbl.push_back(mk(1,1,16'h0012,0,1, 0,0,0,0, 0,0, 1,0, 16'h12EF,16'hABCD,0,0));
    tbl.push_back(mk(1,1,16'h9955,0,0, 0,0,0,0, 0,0, 1,0, 16'h1255,16'hABCD,0,0));
    tbl.push_back(mk(1,4,16'h0001,1,0, 0,0,0,0, 0,0, 4,1, 16'h0001,16'h1255,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0, 1,4,1,1, 0,0, 4,4, 16'hFFFF,16'hFFFF,1,0));
    tbl.push_back(mk(0,0,16'h0000,0,0, 1,4,0,0, 0,0, 4,0, 16'h0000,16'hABCD,1,0));
    tbl.push_back(mk(0,0,16'h0000,0,0, 0,0,0,0, 0,0, 4,0, 16'h0000,16'hABCD,0,0));
    tbl.push_back(mk(1,2,16'h0010,1,0, 0,0,0,0, 0,0, 2,4, 16'h0010,16'h0000,0,0));
    tbl.push_back(mk(1,2,16'h1111,1,0, 1,2,0,0, 0,0, 2,2, 16'h1111,16'h1111,0,0));
    tbl.push_back(mk(1,3,16'h3333,1,0, 1,2,0,1, 0,0, 2,3, 16'h1113,16'h3333,0,0));
    tbl.push_back(mk(1,5,16'hFFFF,1,0, 0,0,0,0, 0,0, 5,5, 16'hFFFF,16'hFFFF,0,0));
    tbl.push_back(mk(1,5,16'h0001,1,0, 1,5,0,0, 0,0, 5,5, 16'h0001,16'h0001,0,0));
    tbl.push_back(mk(1,0,16'hAAAA,1,0, 0,0,0,0, 0,0, 0,0, 16'hAAAA,16'hAAAA,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0, 0,0,0,0, 1,0, 0,2, 16'hAAAA,16'h1113,0,1));
    tbl.push_back(mk(1,0,16'h5555,1,0, 0,0,0,0, 0,0, 0,2, 16'h5555,16'h1113,0,1));
    tbl.push_back(mk(1,0,16'h7777,1,0, 1,2,0,0, 0,1, 0,2, 16'hAAAA,16'h1113,0,0));
    tbl.push_back(mk(1,0,16'hBBBB,1,0, 0,0,0,0, 0,0, 0,5, 16'hBBBB,16'h0001,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0, 0,0,0,0, 1,1, 0,0, 16'hAAAA,16'hAAAA,0,1));
    tbl.push_back(mk(0,0,16'h0000,0,0, 0,0,0,0, 0,1, 0,5, 16'hBBBB,16'h0001,0,0));
    tbl.push_back(mk(1,0,16'hCCCC,1,0, 0,0,0,0, 0,0, 0,0, 16'hCCCC,16'hCCCC,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0, 0,0,0,0, 0,1, 0,1, 16'hBBBB,16'h1255,0,0));

    foreach (tbl[i]) begin
      model_edge(tbl[i], dummy);
      drive(tbl[i]);
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i), tbl[i]);
    end

    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v = mk($urandom_range(0,1), 3'($urandom), 16'($urandom),
             $urandom_range(0,1), $urandom_range(0,1),
             $urandom_range(0,1), 3'($urandom),
             $urandom_range(0,1), $urandom_range(0,1),
             ($urandom_range(0,15) == 0), ($urandom_range(0,15) == 0),
             3'($urandom), 3'($urandom), 0,0,0,0);
      if ($urandom_range(0,3) == 0) v.sr = v.wr;
      if ($urandom_range(0,3) == 0) begin
        v.st = 1;
        v.by2 = 1;
        v.wd = $urandom_range(0,1) ? 16'hFFFF : 16'h0001;
      end
      run_model($sformatf("rnd%0d", n), v);
    end

    drive(mk(1,6,16'h4321,1,0, 1,6,0,0, 1,1, 6,6, 0,0,0,0));
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_out("async_reset", mk(0,0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0));
    @(posedge clk); #1;
    check_out("reset_hold", mk(0,0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0));
    #2 reset = 1'b1;
    model_reset();
    run_model("first_edge", mk(1,7,16'h1234,1,0, 0,0,0,0, 0,0, 7,0, 0,0,0,0));
    for (int i = 0; i < 4; i++)
      run_model($sformatf("post_reset%0d", i),
                mk(0,0,0,0,0, 0,0,0,0, 0,0, 3'(2*i), 3'(2*i+1), 0,0,0,0));
    run_model("shadow_cleared", mk(0,0,0,0,0, 0,0,0,0, 0,1, 7,3, 0,0,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
